// File: rtl/apu_note_sequencer.sv
// apu_note_sequencer: buffers note commands in a FIFO and replays each as a four-write APU register burst,
// with per-channel tick-driven duration counters that trigger automatic key-off writes.
module apu_note_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_chan,
    input  logic [2:0]                    cmd_wave,
    input  logic [15:0]                   cmd_freq,
    input  logic [7:0]                    cmd_vol,
    input  logic [15:0]                   cmd_dur,
    input  logic                          tick,
    output logic [7:0]                    apu_addr,
    output logic [15:0]                   apu_wdata,
    output logic                          apu_we,
    output logic [3:0]                    ch_active,
    output logic [3:0]                    ch_done,
    input  logic [3:0]                    done_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [2:0] IDLE = 3'd0, KOFF = 3'd1, W_FLO = 3'd2, W_FHI = 3'd3, W_VOL = 3'd4, W_CTRL = 3'd5;

    logic [2:0]    state;
    logic [44:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [1:0]    ch, koff_sel;
    logic [2:0]    wave;
    logic [15:0]   freq, dur;
    logic [7:0]    vol;
    logic [3:0]    keyoff_pending;
    logic [15:0]   remaining [4];
    logic          push, pop;

    assign cmd_ready = fifo_count < FULL;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state == IDLE && keyoff_pending == 4'd0 && fifo_count != '0;
    assign busy      = state != IDLE;
    assign apu_we    = busy;

    always_comb begin
        koff_sel = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (keyoff_pending[i]) koff_sel = 2'(i);
    end

    // Register offsets within a channel's 8-byte window: 0 ctrl, 1 freq lo, 2 freq hi, 3 volume.
    always_comb begin
        apu_addr  = state == IDLE ? 8'h00 :
                    {3'b000, ch, state == W_FLO ? 3'd1 : state == W_FHI ? 3'd2 : state == W_VOL ? 3'd3 : 3'd0};
        apu_wdata = state == W_FLO  ? {8'h00, freq[7:0]} :
                    state == W_FHI  ? {8'h00, freq[15:8]} :
                    state == W_VOL  ? {8'h00, vol} :
                    state == W_CTRL ? {12'h000, wave, 1'b1} : 16'h0000;
    end

    always_ff @(posedge clk)
        if (push) mem[wptr] <= {cmd_chan, cmd_wave, cmd_freq, cmd_vol, cmd_dur};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end

    // Pending key-offs are serviced before new notes are popped.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            ch    <= 2'd0;
            wave  <= 3'd0;
            freq  <= 16'd0;
            vol   <= 8'd0;
            dur   <= 16'd0;
        end else begin
            case (state)
                IDLE:
                    if (|keyoff_pending) begin
                        ch    <= koff_sel;
                        state <= KOFF;
                    end else if (pop) begin
                        {ch, wave, freq, vol, dur} <= mem[rptr];
                        state <= W_FLO;
                    end
                W_FLO:   state <= W_FHI;
                W_FHI:   state <= W_VOL;
                W_VOL:   state <= W_CTRL;
                default: state <= IDLE;
            endcase
        end

    // A note load on the ctrl write overrides any same-edge tick for that channel; dur=0 sustains.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ch_active      <= 4'd0;
            ch_done        <= 4'd0;
            keyoff_pending <= 4'd0;
            for (int i = 0; i < 4; i++) remaining[i] <= 16'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (state == W_CTRL && ch == 2'(i)) begin
                    remaining[i]      <= dur;
                    ch_active[i]      <= 1'b1;
                    keyoff_pending[i] <= 1'b0;
                    ch_done[i]        <= 1'b0;
                end else if (state == KOFF && ch == 2'(i)) begin
                    ch_active[i]      <= 1'b0;
                    keyoff_pending[i] <= 1'b0;
                    ch_done[i]        <= 1'b1;
                end else begin
                    if (done_clr[i]) ch_done[i] <= 1'b0;
                    if (tick && ch_active[i] && remaining[i] != 16'd0) begin
                        remaining[i] <= remaining[i] - 16'd1;
                        if (remaining[i] == 16'd1) keyoff_pending[i] <= 1'b1;
                    end
                end
            end
        end
endmodule

// File: tb/tb_apu_note_sequencer.sv
// tb_apu_note_sequencer: directed checks of the note sequencer write bursts, FIFO flow,
// duration/key-off timing and reset behaviour.
module tb_apu_note_sequencer;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_chan = '0;
    logic [2:0]  cmd_wave = '0;
    logic [15:0] cmd_freq = '0, cmd_dur = '0;
    logic [7:0]  cmd_vol = '0;
    logic        tick = 1'b0;
    logic [7:0]  apu_addr;
    logic [15:0] apu_wdata;
    logic        apu_we;
    logic [3:0]  ch_active, ch_done, done_clr = '0;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic        busy;

    apu_note_sequencer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chan(cmd_chan), .cmd_wave(cmd_wave), .cmd_freq(cmd_freq), .cmd_vol(cmd_vol),
        .cmd_dur(cmd_dur), .tick(tick), .apu_addr(apu_addr), .apu_wdata(apu_wdata),
        .apu_we(apu_we), .ch_active(ch_active), .ch_done(ch_done), .done_clr(done_clr),
        .fifo_count(fifo_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // w[k] = {addr, data} of the k-th write of the burst
    typedef struct packed {
        logic [1:0]        chan;
        logic [2:0]        wave;
        logic [15:0]       freq;
        logic [7:0]        vol;
        logic [15:0]       dur;
        logic [0:3][23:0]  w;
        logic [3:0]        act;
    } vec_t;

    vec_t tbl [4];
    vec_t n26, n_tc, n_p, n_s, r1, r2;
    int nc = 0, nf = 0, cyc = 0;
    bit mon_en = 1'b0;
    logic [23:0] wq [$];
    int wc [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (mon_en && apu_we) begin
            wq.push_back({apu_addr, apu_wdata});
            wc.push_back(cyc);
        end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nc++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        wq.delete();
        wc.delete();
    endtask

    task automatic run_note(input vec_t v, input bit tick_ctrl);
        cmd_chan = v.chan; cmd_wave = v.wave; cmd_freq = v.freq; cmd_vol = v.vol; cmd_dur = v.dur;
        cmd_valid = 1'b1;
        chk("note_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("note_lat_idle", apu_we, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("note_we", apu_we, 1);
            chk("note_addr", apu_addr, v.w[k][23:16]);
            chk("note_data", apu_wdata, v.w[k][15:0]);
            if (k == 3 && tick_ctrl) tick = 1'b1;
        end
        step();
        tick = 1'b0;
        chk("note_we_end", apu_we, 0);
        chk("note_busy_end", busy, 0);
    endtask

    function automatic logic [23:0] ew(input logic [1:0] c, input logic [2:0] w, input logic [15:0] f,
                                       input logic [7:0] v, input int k);
        logic [7:0] b;
        b = {3'b000, c, 3'b000};
        case (k)
            0:       return {b | 8'd1, 8'h00, f[7:0]};
            1:       return {b | 8'd2, 8'h00, f[15:8]};
            2:       return {b | 8'd3, 8'h00, v};
            default: return {b, 12'h000, w, 1'b1};
        endcase
    endfunction

    initial begin
        logic [1:0]  dc [5];
        logic [2:0]  dw [5];
        logic [15:0] df [5];
        logic [7:0]  dv [5];
        int maxg;
        tbl[0] = {2'd2, 3'd1, 16'h1234, 8'h80, 16'd0, 24'h110034, 24'h120012, 24'h130080, 24'h100003, 4'b0100};
        tbl[1] = {2'd0, 3'd7, 16'hABCD, 8'hFF, 16'd0, 24'h0100CD, 24'h0200AB, 24'h0300FF, 24'h00000F, 4'b0101};
        tbl[2] = {2'd3, 3'd0, 16'h00FF, 8'h01, 16'd0, 24'h1900FF, 24'h1A0000, 24'h1B0001, 24'h180001, 4'b1101};
        tbl[3] = {2'd1, 3'd5, 16'hFF00, 8'h7E, 16'd0, 24'h090000, 24'h0A00FF, 24'h0B007E, 24'h08000B, 4'b1111};
        n26  = {2'd2, 3'd1, 16'h1234, 8'h80, 16'd3, 24'h110034, 24'h120012, 24'h130080, 24'h100003, 4'b1111};
        n_tc = {2'd0, 3'd2, 16'h0010, 8'h20, 16'd2, 24'h010010, 24'h020000, 24'h030020, 24'h000005, 4'b0000};
        n_p  = {2'd0, 3'd3, 16'h0102, 8'h11, 16'd1, 24'h010002, 24'h020001, 24'h030011, 24'h000007, 4'b0000};
        n_s  = {2'd1, 3'd1, 16'h0001, 8'h02, 16'd0, 24'h090001, 24'h0A0000, 24'h0B0002, 24'h080003, 4'b0010};
        r1   = {2'd3, 3'd2, 16'h0300, 8'h40, 16'd2, 24'h190000, 24'h1A0003, 24'h1B0040, 24'h180005, 4'b0000};
        r2   = {2'd3, 3'd2, 16'h0300, 8'h40, 16'd5, 24'h190000, 24'h1A0003, 24'h1B0040, 24'h180005, 4'b0000};

        // reset state
        step();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_we", apu_we, 0);
        chk("rst_addr", apu_addr, 0);
        chk("rst_wdata", apu_wdata, 0);
        chk("rst_active", ch_active, 0);
        chk("rst_done", ch_done, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        step();

        // table of single notes, all sustained
        for (int i = 0; i < 4; i++) begin
            run_note(tbl[i], 1'b0);
            chk("tbl_active", ch_active, tbl[i].act);
        end

        // single note with duration 3 (restarting active ch2), then key-off and done_clr race
        run_note(n26, 1'b0);
        chk("n26_active", ch_active, 4'b1111);
        for (int t = 0; t < 2; t++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
            chk("n26_no_koff", apu_we, 0);
        end
        tick = 1'b1; step(); tick = 1'b0;
        chk("n26_idle_before_koff", apu_we, 0);
        step();
        chk("n26_koff_we", apu_we, 1);
        chk("n26_koff_addr", apu_addr, 8'h10);
        chk("n26_koff_data", apu_wdata, 16'h0000);
        done_clr = 4'b0100;
        step();
        done_clr = 4'b0000;
        chk("done_set_wins", ch_done, 4'b0100);
        chk("n26_active_after", ch_active, 4'b1011);
        chk("n26_we_after", apu_we, 0);
        done_clr = 4'b0100;
        step();
        done_clr = 4'b0000;
        chk("done_clr", ch_done, 4'b0000);

        // tick coincident with the ctrl write must not decrement
        run_note(n_tc, 1'b1);
        tick = 1'b1; step(); tick = 1'b0; step();
        chk("tc_no_koff", apu_we, 0);
        tick = 1'b1; step(); tick = 1'b0;
        chk("tc_idle", apu_we, 0);
        step();
        chk("tc_koff_we", apu_we, 1);
        chk("tc_koff_addr", apu_addr, 8'h00);
        step();

        // key-off has priority over a queued note
        run_note(n_p, 1'b0);
        cmd_chan = 2'd2; cmd_wave = 3'd4; cmd_freq = 16'h5678; cmd_vol = 8'h33; cmd_dur = 16'd0;
        cmd_valid = 1'b1; tick = 1'b1;
        step();
        cmd_valid = 1'b0; tick = 1'b0;
        chk("prio_count", fifo_count, 1);
        chk("prio_idle", apu_we, 0);
        step();
        chk("prio_koff_we", apu_we, 1);
        chk("prio_koff_addr", apu_addr, 8'h00);
        chk("prio_koff_data", apu_wdata, 16'h0000);
        step();
        chk("prio_gap", apu_we, 0);
        step();
        chk("prio_next_addr", apu_addr, 8'h11);
        chk("prio_next_data", apu_wdata, 16'h0078);
        repeat (4) step();
        chk("prio_busy_end", busy, 0);

        // five back-to-back commands against a depth-4 FIFO
        mon_clear();
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dc[i] = 2'(i % 4); dw[i] = 3'(i + 1); df[i] = 16'h2040 + 16'(i * 257); dv[i] = 8'h50 + 8'(i);
            cmd_chan = dc[i]; cmd_wave = dw[i]; cmd_freq = df[i]; cmd_vol = dv[i]; cmd_dur = 16'd0;
            cmd_valid = 1'b1;
            chk("b2b_ready", cmd_ready, 1);
            step();
            if (i == 1) chk("b2b_push_pop_count", fifo_count, 1);
        end
        cmd_valid = 1'b0;
        chk("b2b_full_count", fifo_count, 4);
        chk("b2b_full_ready", cmd_ready, 0);
        repeat (40) step();
        chk("b2b_nwrites", wq.size(), 20);
        if (wq.size() == 20) begin
            for (int j = 0; j < 20; j++) chk("b2b_write", wq[j], ew(dc[j / 4], dw[j / 4], df[j / 4], dv[j / 4], j % 4));
            maxg = 0;
            for (int j = 1; j < 20; j++) if (wc[j] - wc[j - 1] > maxg) maxg = wc[j] - wc[j - 1];
            chk("b2b_max_gap", maxg, 2);
        end
        mon_en = 1'b0;

        // sustain, then retrigger
        reset = 1'b1; step(); reset = 1'b0; step();
        run_note(n_s, 1'b0);
        mon_clear();
        mon_en = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        chk("sustain_no_write", wq.size(), 0);
        chk("sustain_active", ch_active, 4'b0010);
        mon_en = 1'b0;
        run_note(r1, 1'b0);
        tick = 1'b1; step(); tick = 1'b0; step();
        run_note(r2, 1'b0);
        mon_clear();
        mon_en = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            tick = 1'b1; step(); tick = 1'b0; step(); step();
            if (t < 5) chk("retrig_no_koff", wq.size(), 0);
            else begin
                chk("retrig_koff_count", wq.size(), 1);
                if (wq.size() == 1) chk("retrig_koff_write", wq[0], 24'h180000);
            end
        end
        mon_en = 1'b0;
        chk("retrig_done", ch_done, 4'b1000);

        // reset asserted during the volume write
        cmd_chan = 2'd2; cmd_wave = 3'd6; cmd_freq = 16'h4321; cmd_vol = 8'h44; cmd_dur = 16'd0;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (3) step();
        chk("mid_wvol_addr", apu_addr, 8'h13);
        chk("mid_wvol_data", apu_wdata, 16'h0044);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", apu_we, 0);
        chk("mid_rst_addr", apu_addr, 0);
        chk("mid_rst_wdata", apu_wdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_active", ch_active, 0);
        chk("mid_rst_done", ch_done, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        mon_clear();
        mon_en = 1'b1;
        step();
        reset = 1'b0;
        repeat (10) step();
        chk("mid_rst_no_writes", wq.size(), 0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end
endmodule
